uart_msg_rx: RTL and testbench

- UART 8N1 receiver: deserialises bytes from the `rx` line and assembles them into a `#`-terminated message of up to 8 characters.
- Presents the message as a packed word, bit-compatible with the Verilog string literals the transmit side sends (e.g. "GBI3-D-#").
- Sits between the board's RX pin and the top-level run controller, so the bot can accept node/colour commands over the same serial link.

---
 rtl/uart_msg_pkg.sv | 42 ++++
 rtl/uart_msg_rx_byte.sv | 125 ++++++++++++
 rtl/uart_msg_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_msg_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the UART message receiver: RX bit-FSM states,
// terminator default, colour codes and the "GBI<d>-<X>-#" command decoder.
package uart_msg_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] TERM_CHAR_DEF = 8'h23;

    // Same codes the colour sensor path produces
    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b001;

    typedef struct packed {
        logic       ok;
        logic [3:0] node;
        logic [2:0] color;
    } gbi_cmd_t;

    function automatic gbi_cmd_t parse_gbi(input logic [63:0] m);
        gbi_cmd_t r;
        r.ok    = (m[63:40] == "GBI") && (m[31:24] == "-") && (m[15:0] == "-#") &&
                  (m[39:32] >= "0") && (m[39:32] <= "9");
        r.node  = m[35:32];
        case (m[23:16])
            "D":     r.color = COL_GREEN;
            "W":     r.color = COL_BLUE;
            "M":     r.color = COL_RED;
            default: begin
                r.color = '0;
                r.ok    = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_msg_rx_byte.sv
// UART 8N1 byte receiver: 2-FF synchroniser, bit FSM and baud counter.
// Emits a registered one-cycle valid (good stop bit) or frame_err pulse.
module uart_rx_byte
    import uart_msg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            armed_q, armed_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        armed_d = armed_q;
        valid_d = 1'b0;
        data_d  = data_q;
        ferr_d  = 1'b0;
        case (state_q)
            // Re-arm only after the line has been seen high, so a held-low line cannot retrigger
            RX_IDLE: begin
                if (!armed_q) begin
                    armed_d = rx_s;
                end else if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_msg_rx.sv
// UART message receiver: assembles TERM_CHAR-terminated messages of up to MAX_CHARS bytes.
// Define UART_MSG_PARSE_EN to enable the "GBI<d>-<X>-#" node/colour parser.
module uart_msg_rx
    import uart_msg_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned MAX_CHARS = 8,
    parameter logic [7:0]  TERM_CHAR = TERM_CHAR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic                     byte_valid,
    output logic [7:0]               byte_data,
    output logic                     msg_valid,
    output logic [8*MAX_CHARS-1:0]   msg,
    output logic [3:0]               msg_len,
    output logic                     frame_err,
    output logic                     ovf_err,
    output logic                     busy,
    output logic [3:0]               node_id,
    output logic [2:0]               color,
    output logic                     parse_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned MW           = 8 * MAX_CHARS;
    localparam logic [3:0]  MAX_C        = 4'(MAX_CHARS);

    logic          rx_valid, rx_ferr;
    logic [7:0]    rx_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .valid_o     (rx_valid),
        .data_o      (rx_data),
        .frame_err_o (rx_ferr),
        .busy_o      (busy)
    );

    // At most MAX_CHARS-1 bytes are ever held; the last one is either the terminator or an overflow
    logic [MW-9:0] mbuf_q, mbuf_d;
    logic [MW-1:0] shifted;
    logic [3:0]    count_q, count_d;
    logic [MW-1:0] msg_q, msg_d;
    logic [3:0]    len_q, len_d;
    logic          bv_q, bv_d;
    logic [7:0]    bd_q, bd_d;
    logic          mv_q, mv_d;
    logic          ovf_q, ovf_d;
    logic          fe_q, fe_d;
    logic          term_hit;

    assign shifted  = {mbuf_q, rx_data};
    assign term_hit = rx_valid && (rx_data == TERM_CHAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            mbuf_q  <= '0;
            count_q <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            bv_q    <= 1'b0;
            bd_q    <= '0;
            mv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            mbuf_q  <= mbuf_d;
            count_q <= count_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            bv_q    <= bv_d;
            bd_q    <= bd_d;
            mv_q    <= mv_d;
            ovf_q   <= ovf_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        mbuf_d  = mbuf_q;
        count_d = count_q;
        msg_d   = msg_q;
        len_d   = len_q;
        bv_d    = 1'b0;
        bd_d    = bd_q;
        mv_d    = 1'b0;
        ovf_d   = 1'b0;
        fe_d    = 1'b0;
        if (rx_valid) begin
            bv_d = 1'b1;
            bd_d = rx_data;
            if (term_hit) begin
                msg_d   = shifted;
                len_d   = count_q + 4'd1;
                mv_d    = 1'b1;
                mbuf_d  = '0;
                count_d = '0;
            end else if (count_q + 4'd1 == MAX_C) begin
                ovf_d   = 1'b1;
                mbuf_d  = '0;
                count_d = '0;
            end else begin
                mbuf_d  = shifted[MW-9:0];
                count_d = count_q + 4'd1;
            end
        end else if (rx_ferr) begin
            fe_d    = 1'b1;
            mbuf_d  = '0;
            count_d = '0;
        end
    end

    assign byte_valid = bv_q;
    assign byte_data  = bd_q;
    assign msg_valid  = mv_q;
    assign msg        = msg_q;
    assign msg_len    = len_q;
    assign ovf_err    = ovf_q;
    assign frame_err  = fe_q;

`ifdef UART_MSG_PARSE_EN
    logic [3:0] node_q, node_d;
    logic [2:0] color_q, color_d;
    logic       perr_q, perr_d;
    gbi_cmd_t   cmd;

    always_comb begin
        cmd     = parse_gbi(shifted[63:0]);
        node_d  = node_q;
        color_d = color_q;
        perr_d  = 1'b0;
        if (term_hit) begin
            if ((count_q == 4'd7) && cmd.ok) begin
                node_d  = cmd.node;
                color_d = cmd.color;
            end else begin
                perr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            node_q  <= '0;
            color_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            node_q  <= node_d;
            color_q <= color_d;
            perr_q  <= perr_d;
        end
    end

    assign node_id   = node_q;
    assign color     = color_q;
    assign parse_err = perr_q;
`else
    assign node_id   = '0;
    assign color     = '0;
    assign parse_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_msg_rx.sv
// Self-checking bench for uart_msg_rx: directed messages, error cases and random
// byte streams checked against a queue-based message model.
module tb_uart_msg_rx;

    localparam int unsigned CLK_FREQ = 50000000;
    localparam int unsigned BAUD     = 1562500;
    localparam int unsigned CPB      = CLK_FREQ / BAUD;
    localparam int unsigned MAXC     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        byte_valid, msg_valid, frame_err, ovf_err, busy, parse_err;
    logic [7:0]  byte_data;
    logic [63:0] msg;
    logic [3:0]  msg_len, node_id;
    logic [2:0]  color;

    uart_msg_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .MAX_CHARS (MAXC),
        .TERM_CHAR (8'h23)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .msg_valid  (msg_valid),
        .msg        (msg),
        .msg_len    (msg_len),
        .frame_err  (frame_err),
        .ovf_err    (ovf_err),
        .busy       (busy),
        .node_id    (node_id),
        .color      (color),
        .parse_err  (parse_err)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          bv_cnt = 0, mv_cnt = 0, ovf_cnt = 0, fe_cnt = 0, perr_cnt = 0, coinc_bad = 0;
    logic [63:0] last_msg = '0;
    logic [3:0]  last_len = '0;

    always @(negedge clk) begin
        if (byte_valid) bv_cnt++;
        if (msg_valid) begin
            mv_cnt++;
            last_msg = msg;
            last_len = msg_len;
            if (!byte_valid) coinc_bad++;
        end
        if (ovf_err) ovf_cnt++;
        if (parse_err) perr_cnt++;
        if (frame_err) begin
            fe_cnt++;
            if (msg_valid || byte_valid) coinc_bad++;
        end
    end

    // Reference model: pending characters kept in a queue
    logic [7:0]  mq[$];
    int          exp_bv = 0, exp_mv = 0, exp_ovf = 0, exp_fe = 0;
    logic [63:0] exp_msg = '0;
    logic [3:0]  exp_len = '0;
    logic [7:0]  exp_byte = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_good(input logic [7:0] b);
        exp_bv++;
        exp_byte = b;
        mq.push_back(b);
        if (b == 8'h23) begin
            exp_mv++;
            exp_len = 4'(mq.size());
            exp_msg = '0;
            foreach (mq[i]) exp_msg = (exp_msg << 8) | 64'(mq[i]);
            mq.delete();
        end else if (mq.size() == MAXC) begin
            exp_ovf++;
            mq.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic after);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = after;
        repeat (4) @(negedge clk);
        if (stop) model_good(b);
        else begin
            exp_fe++;
            mq.delete();
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 1'b1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " byte_valid count"}, 64'(bv_cnt), 64'(exp_bv));
        chk({tag, " msg_valid count"}, 64'(mv_cnt), 64'(exp_mv));
        chk({tag, " ovf count"}, 64'(ovf_cnt), 64'(exp_ovf));
        chk({tag, " frame_err count"}, 64'(fe_cnt), 64'(exp_fe));
        chk({tag, " msg"}, last_msg, exp_msg);
        chk({tag, " msg_len"}, 64'(last_len), 64'(exp_len));
        chk({tag, " byte_data"}, 64'(byte_data), 64'(exp_byte));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          perr0;
        logic [7:0]  b;

        repeat (5) @(negedge clk);
        chk("reset ctrl outputs",
            64'({byte_valid, msg_valid, frame_err, ovf_err, busy, parse_err, node_id, color, msg_len}), 64'd0);
        chk("reset msg", msg, 64'd0);
        chk("reset byte_data", 64'(byte_data), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        perr0 = perr_cnt;
        send_str("GBI3-D-#");
        check_all("gbi");
        chk("gbi msg const", last_msg, 64'h4742_4933_2D44_2D23);
        chk("gbi len const", 64'(last_len), 64'd8);
`ifdef UART_MSG_PARSE_EN
        chk("gbi node_id", 64'(node_id), 64'd3);
        chk("gbi color", 64'(color), 64'(3'b010));
        chk("gbi no parse_err", 64'(perr_cnt - perr0), 64'd0);
`else
        chk("parser off node/color", 64'({node_id, color}), 64'd0);
`endif

        send_str("AB#");
        check_all("ab");
        chk("ab msg const", last_msg, 64'h0000_0000_0041_4223);
`ifdef UART_MSG_PARSE_EN
        chk("ab keeps node_id", 64'(node_id), 64'd3);
        chk("ab parse_err", 64'(perr_cnt - perr0), 64'd1);
`endif

        send_str("#");
        check_all("empty");
        chk("empty msg const", last_msg, 64'h23);

        // Frame error clears partially assembled characters
        send_str("CD");
        send_frame(8'h55, 1'b0, 1'b1);
        check_all("ferr");
        send_str("X#");
        check_all("ferr next");
        chk("ferr next msg const", last_msg, 64'h5823);

        // Frame error followed by a held-low line must not retrigger
        send_frame(8'h55, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("held low no retrigger", 64'(n), 64'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check_all("held low");

        send_str("ABCDEFGH");
        check_all("ovf");
        send_str("Z#");
        check_all("ovf next");
        chk("ovf next msg const", last_msg, 64'h5A23);

        // Short low glitch: START rejects it, busy falls within half a bit
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("glitch busy rise", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("glitch busy within half bit", 64'(n <= int'(CPB / 2 + 1)), 64'd1);
        repeat (CPB) @(negedge clk);
        check_all("glitch");

        // Reset in the middle of bit 4 of a frame, with one character pending
        send_str("K");
        b = 8'h96;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midframe rst ctrl outputs",
            64'({byte_valid, msg_valid, frame_err, ovf_err, busy, parse_err, node_id, color, msg_len}), 64'd0);
        chk("midframe rst msg", msg, 64'd0);
        chk("midframe rst byte_data", 64'(byte_data), 64'd0);
        rst = 1'b0;
        rx  = 1'b1;
        mq.delete();
        exp_byte = '0;
        repeat (10) @(negedge clk);
        check_all("after rst");
        send_str("Q#");
        check_all("after rst msg");
        chk("after rst msg const", last_msg, 64'h5123);

        // Random byte streams, some long enough to overflow
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, 11);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h23) b = 8'h2A;
                send_frame(b, 1'b1, 1'b1);
            end
            send_frame(8'h23, 1'b1, 1'b1);
            check_all("random");
        end

        chk("frame_err/msg_valid exclusivity", 64'(coinc_bad), 64'd0);
`ifndef UART_MSG_PARSE_EN
        chk("parser off parse_err", 64'(perr_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
